// File: rtl/mux_2_1.sv
// Advance-pulse source selector: run-mode prescaler tick or push-button step/repeat.
// Ports: clk, rst (async high), mode[1:0], change (async button), out (1-clk pulse). Option: DEBOUNCE_EN.
module mux_2_1 #(
  parameter int DIV           = 50_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int DEB_CYCLES    = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       change,
  output logic       out
);

  localparam logic [1:0] M_RUN  = 2'd0;
  localparam logic [1:0] M_STEP = 2'd1;
  localparam logic [1:0] M_REP  = 2'd2;
  localparam logic [1:0] M_HOLD = 2'd3;

  localparam int PW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic          s1_q, s2_q, s3_q;
  logic [1:0]    fill_q;
  logic          armed;
  logic          filt;
  logic          rise;
  logic [PW-1:0] presc_q, presc_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          ph_q, ph_d;
  logic          out_q, out_d;

  // The synchronizer holds reset zeros for its first edges; a level
  // already high at reset release must not look like a press.
  assign armed = (fill_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fill_q <= 2'd0;
    end else begin
      s1_q <= change;
      s2_q <= s1_q;
      s3_q <= armed ? filt : s2_q;
      if (!armed) fill_q <= fill_q + 2'd1;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic          filt_q;
  logic [DW-1:0] deb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 1'b0;
      deb_q  <= '0;
    end else if (!armed) begin
      filt_q <= s2_q;
      deb_q  <= '0;
    end else if (s2_q != filt_q) begin
      if (deb_q == DW'(DEB_CYCLES - 1)) begin
        filt_q <= s2_q;
        deb_q  <= '0;
      end else begin
        deb_q <= deb_q + 1'b1;
      end
    end else begin
      deb_q <= '0;
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2_q;
`endif

  assign rise = armed & filt & ~s3_q;

  // Every counter falls back to zero unless its own mode keeps it
  // alive, so switching modes discards all pending progress.
  always_comb begin
    presc_d = '0;
    rep_d   = '0;
    ph_d    = 1'b0;
    out_d   = 1'b0;
    unique case (mode)
      M_RUN: begin
        out_d   = (presc_q == PW'(DIV - 1));
        presc_d = out_d ? '0 : presc_q + 1'b1;
      end
      M_STEP: out_d = rise;
      M_REP: begin
        if (filt) begin
          if (rise) begin
            out_d = 1'b1;
            rep_d = RW'(1);
          end else if (rep_q != '0) begin
            // ph_q: 0 = waiting initial delay, 1 = periodic phase
            if (rep_q == (ph_q ? RW'(REPEAT_PERIOD)
                               : RW'(REPEAT_DELAY))) begin
              out_d = 1'b1;
              rep_d = RW'(1);
              ph_d  = 1'b1;
            end else begin
              rep_d = rep_q + 1'b1;
              ph_d  = ph_q;
            end
          end
        end
      end
      M_HOLD: out_d = 1'b0;
      default: out_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      rep_q   <= '0;
      ph_q    <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      rep_q   <= rep_d;
      ph_q    <= ph_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mux_2_1.sv
// Directed bench for mux_2_1 with small timing parameters.
// Pulse positions are counted in edges after each stimulus change.
module tb_mux_2_1;

`ifdef DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       change;
  logic       out;

  int total;
  int bad;
  int idx;
  int hits[$];
  int expq[$];

  mux_2_1 #(
    .DIV(4),
    .REPEAT_DELAY(6),
    .REPEAT_PERIOD(3),
    .DEB_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .change(change),
    .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    idx = 0;
    hits.delete();
    expq.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      idx++;
      if (out === 1'b1) hits.push_back(idx);
    end
  endtask

  task automatic cmp_hits(input string tag);
    int g;
    chk({tag, "_n"}, hits.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      g = (i < hits.size()) ? hits[i] : -1;
      chk({tag, "_pos"}, g, expq[i]);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    mode   = 2'd1;
    change = 1'b1;
    #1;
    chk("rst_out0", out, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out", out, 0);
    end
    rst = 1'b0;
    clr();
    run(12);
    cmp_hits("no_rise");

    mode   = 2'd0;
    change = 1'b0;
    clr();
    run(20);
    expq = '{4, 8, 12, 16, 20};
    cmp_hits("run");

    clr();
    run(2);
    mode = 2'd1;
    clr();
    run(8);
    cmp_hits("sw_stray");

    change = 1'b1;
    clr();
    run(12);
    expq = '{LAT};
    cmp_hits("step");
    change = 1'b0;
    clr();
    run(10);
    cmp_hits("step_rel");

    mode   = 2'd2;
    change = 1'b1;
    clr();
    run(20);
    change = 1'b0;
    run(12);
    expq = '{LAT, LAT + 6, LAT + 9, LAT + 12, LAT + 15, LAT + 18};
    cmp_hits("rep");

    mode = 2'd3;
    clr();
    change = 1'b1;
    run(4);
    change = 1'b0;
    run(4);
    change = 1'b1;
    run(12);
    cmp_hits("hold");
    mode = 2'd1;
    clr();
    run(10);
    cmp_hits("no_replay");

    change = 1'b0;
    run(10);
    change = 1'b1;
    for (int i = 0; i < LAT; i++) step();
    chk("pre_rst_pulse", out, 1);
    rst = 1'b1;
    #1;
    chk("async_rst", out, 0);
    step();
    rst = 1'b0;
    change = 1'b0;
    clr();
    run(10);
    cmp_hits("post_rst");

`ifdef DEBOUNCE_EN
    mode   = 2'd1;
    change = 1'b0;
    run(8);
    clr();
    change = 1'b1;
    run(2);
    change = 1'b0;
    run(10);
    cmp_hits("glitch");
    clr();
    change = 1'b1;
    run(10);
    expq = '{6};
    cmp_hits("deb_press");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
